// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential execute-stage ALU (alu_seq_exec):
//   - 4-bit ALU control code constants as produced by the ALU controller
//   - FSM state type for the top-level sequencer
//   - is_legal_ctrl(): reports whether a control code is implemented
// Optional feature macro (consumed by the RTL files): ALU_SEQ_MULHI_EN
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_MUL,
      ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle,
// always exactly WIDTH iterations (no early exit on a zero multiplier).
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-low reset
//   start_i    in   latch a_i/b_i and begin; ignored while busy
//   a_i        in   multiplicand [WIDTH-1:0]
//   b_i        in   multiplier   [WIDTH-1:0]
//   busy_o     out  iterating (the WIDTH cycles after start)
//   done_o     out  high during the final iteration; prod_*_o valid then
//   prod_lo_o  out  low WIDTH bits of the product (next-state value)
//   prod_hi_o  out  high WIDTH bits (only with ALU_SEQ_MULHI_EN)
//
// Macro ALU_SEQ_MULHI_EN widens the partial product to 2*WIDTH so the upper
// half of the unsigned product is available.
// -----------------------------------------------------------------------------
module shift_add_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_lo_o
`ifdef ALU_SEQ_MULHI_EN
  ,
  output logic [WIDTH-1:0] prod_hi_o
`endif
);

`ifdef ALU_SEQ_MULHI_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  // Counter must hold WIDTH after the last increment.
  localparam int CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    part_q,  part_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             last_iter;

  assign last_iter = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i && !busy_q) begin
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      part_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        part_d = part_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_iter) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The product is taken from the next-state partial so the parent can
  // register it on the same edge that retires the final iteration.
  assign busy_o    = busy_q;
  assign done_o    = last_iter;
  assign prod_lo_o = part_d[WIDTH-1:0];
`ifdef ALU_SEQ_MULHI_EN
  assign prod_hi_o = part_d[PW-1:WIDTH];
`endif

endmodule

// File: rtl/alu_seq_exec.sv
// -----------------------------------------------------------------------------
// alu_seq_exec
// Execute-stage ALU with valid/ready handshake. Single-cycle ops (AND, OR,
// ADD, SUB, SLT, NOR) deliver a registered result one cycle after accept;
// MUL runs on shift_add_mul for WIDTH cycles and delivers in cycle WIDTH+1.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-low reset
//   valid_i   in   ctrl/operands valid this cycle
//   ready_o   out  an op can be accepted this cycle
//   ctrl_i    in   4-bit ALU control code (see alu_seq_pkg)
//   src1_i    in   operand A [WIDTH-1:0]
//   src2_i    in   operand B [WIDTH-1:0]
//   valid_o   out  one-cycle pulse: result_o/zero_o/err_o are new
//   result_o  out  registered result [WIDTH-1:0]
//   zero_o    out  result_o == 0
//   err_o     out  accepted control code is illegal
//   hi_o      out  upper half of the MUL product (only with ALU_SEQ_MULHI_EN)
//
// Optional feature macro: ALU_SEQ_MULHI_EN.
// -----------------------------------------------------------------------------
module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
`ifdef ALU_SEQ_MULHI_EN
  ,
  output logic [WIDTH-1:0] hi_o
`endif
);

  state_e           state_q, state_d;
  logic             accept, acc_mul, acc_single;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             err_q,    err_d;
`ifdef ALU_SEQ_MULHI_EN
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] hi_q, hi_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. DONE behaves like IDLE for accepts, so a new op can be
  // taken in the same cycle the MUL result is presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = acc_mul ? MUL : IDLE;
      MUL:        if (mul_done) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_o    = (state_q != MUL) && !mul_busy;
    accept     = valid_i && ready_o;
    acc_mul    = accept && (ctrl_i == ALU_MUL);
    acc_single = accept && (ctrl_i != ALU_MUL);
  end

  // ---------------------------------------------------------------------------
  // Single-cycle op mux. Illegal codes produce 0 so zero_o reads 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    alu_err = !is_legal_ctrl(ctrl_i);
    case (ctrl_i)
      ALU_AND: alu_res = src1_i & src2_i;
      ALU_OR:  alu_res = src1_i | src2_i;
      ALU_ADD: alu_res = src1_i + src2_i;
      ALU_SUB: alu_res = src1_i - src2_i;
      // Signed compare, not the SUB sign bit, so overflow cannot flip it.
      ALU_SLT: alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
      ALU_NOR: alu_res = ~(src1_i | src2_i);
      default: alu_res = '0;
    endcase
  end

  shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (acc_mul),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .prod_lo_o(mul_lo)
`ifdef ALU_SEQ_MULHI_EN
    ,
    .prod_hi_o(mul_hi)
`endif
  );

  // ---------------------------------------------------------------------------
  // Result registers. Completions from the multiplier and single-cycle
  // accepts never coincide (ready_o is low for the whole MUL), so a simple
  // priority is enough. Values hold between completions.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MULHI_EN
    hi_d     = hi_q;
`endif
    if (mul_done) begin
      valid_d  = 1'b1;
      result_d = mul_lo;
      zero_d   = (mul_lo == '0);
      err_d    = 1'b0;
`ifdef ALU_SEQ_MULHI_EN
      hi_d     = mul_hi;
`endif
    end else if (acc_single) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      err_d    = alu_err;
`ifdef ALU_SEQ_MULHI_EN
      hi_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MULHI_EN
      hi_q     <= '0;
`endif
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MULHI_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;
`ifdef ALU_SEQ_MULHI_EN
  assign hi_o     = hi_q;
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_exec
// Directed-vector bench for alu_seq_exec with a transaction-level reference
// model (plain arithmetic, countdown for MUL latency) compared every cycle,
// plus literal expectations on each logged valid_o pulse.
// Honours ALU_SEQ_MULHI_EN for the hi_o port.
// -----------------------------------------------------------------------------
module tb_alu_seq_exec;
  localparam int W = 32;

  logic          clk_i   = 1'b0;
  logic          rst_i   = 1'b0;
  logic          valid_i = 1'b0;
  logic [3:0]    ctrl_i  = 4'd0;
  logic [W-1:0]  src1_i  = '0;
  logic [W-1:0]  src2_i  = '0;
  logic          ready_o, valid_o, zero_o, err_o;
  logic [W-1:0]  result_o;
  logic [W-1:0]  hi_val;
`ifdef ALU_SEQ_MULHI_EN
  logic [W-1:0]  hi_o;
  assign hi_val = hi_o;
`else
  assign hi_val = '0;
`endif

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .valid_o (valid_o),
    .result_o(result_o),
    .zero_o  (zero_o),
    .err_o   (err_o)
`ifdef ALU_SEQ_MULHI_EN
    ,
    .hi_o    (hi_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12};
  endfunction

  logic        m_busy = 1'b0, m_valid = 1'b0, m_zero = 1'b0, m_err = 1'b0;
  logic [31:0] m_res = '0, m_hi = '0;
  logic [63:0] m_prod = '0;
  int          m_left = 0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_zero <= 1'b0; m_err <= 1'b0;
      m_res <= '0; m_hi <= '0; m_prod <= '0; m_left <= 0;
    end else if (m_busy) begin
      m_left  <= m_left - 1;
      m_valid <= (m_left == 1);
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_res  <= m_prod[31:0];
        m_hi   <= m_prod[63:32];
        m_zero <= (m_prod[31:0] == 32'd0);
        m_err  <= 1'b0;
      end
    end else if (valid_i && ctrl_i == 4'd3) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b1;
      m_left  <= W;
      m_prod  <= {32'd0, src1_i} * {32'd0, src2_i};
    end else if (valid_i) begin
      m_valid <= 1'b1;
      m_res   <= ref_result(ctrl_i, src1_i, src2_i);
      m_zero  <= (ref_result(ctrl_i, src1_i, src2_i) == 32'd0);
      m_err   <= !ref_legal(ctrl_i);
      m_hi    <= '0;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  typedef struct {
    int          c;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [31:0] hi;
  } ev_t;
  ev_t log_q[$];

  always @(negedge clk_i) begin
    chk("cyc.ready_o",  64'(ready_o),  64'(!m_busy));
    chk("cyc.valid_o",  64'(valid_o),  64'(m_valid));
    chk("cyc.result_o", 64'(result_o), 64'(m_res));
    chk("cyc.zero_o",   64'(zero_o),   64'(m_zero));
    chk("cyc.err_o",    64'(err_o),    64'(m_err));
`ifdef ALU_SEQ_MULHI_EN
    chk("cyc.hi_o",     64'(hi_o),     64'(m_hi));
`endif
    if (valid_o === 1'b1 && rst_i) log_q.push_back('{cyc, result_o, zero_o, err_o, hi_val});
  end

  task automatic expect_ev(input string name, input int ecyc, input logic [31:0] eres,
                           input logic ez, input logic ee, input logic [31:0] ehi);
    ev_t e;
    if (log_q.size() == 0) begin
      vecs++; miss++;
      $display("FAIL %s: no valid_o pulse seen, expected result %0h", name, eres);
    end else begin
      e = log_q.pop_front();
      chk({name, ".cycle"},  64'(e.c),    64'(ecyc));
      chk({name, ".result"}, 64'(e.res),  64'(eres));
      chk({name, ".zero"},   64'(e.zero), 64'(ez));
      chk({name, ".err"},    64'(e.err),  64'(ee));
`ifdef ALU_SEQ_MULHI_EN
      chk({name, ".hi"},     64'(e.hi),   64'(ehi));
`else
      if (ehi != 32'd0) begin end
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  int c0;

  initial begin
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    idle(2);

    // Reset / idle state
    chk("rst.ready",  64'(ready_o),  64'(1));
    chk("rst.valid",  64'(valid_o),  64'(0));
    chk("rst.result", 64'(result_o), 64'(0));
    chk("rst.zero",   64'(zero_o),   64'(0));
    chk("rst.err",    64'(err_o),    64'(0));

    // Back-to-back single-cycle ops
    c0 = cyc;
    issue(4'd2,  32'd5,        32'd7);
    issue(4'd6,  32'd3,        32'd3);
    issue(4'd7,  32'hFFFFFFFF, 32'd1);
    issue(4'd12, 32'd0,        32'd0);
    idle(2);
    expect_ev("add",  c0 + 1, 32'd12,       1'b0, 1'b0, 32'd0);
    expect_ev("sub",  c0 + 2, 32'd0,        1'b1, 1'b0, 32'd0);
    expect_ev("slt",  c0 + 3, 32'd1,        1'b0, 1'b0, 32'd0);
    expect_ev("nor",  c0 + 4, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);

    // SLT boundary: most-negative < 0
    c0 = cyc;
    issue(4'd7, 32'h80000000, 32'd0);
    idle(1);
    expect_ev("slt_minneg", c0 + 1, 32'd1, 1'b0, 1'b0, 32'd0);

    // MUL with valid_i pulses while busy (must be ignored)
    c0 = cyc;
    issue(4'd3, 32'h00010000, 32'h00010001);
    idle(4);
    issue(4'd2, 32'd9, 32'd9);
    idle(20);
    issue(4'd1, 32'd1, 32'd2);
    idle(12);
    expect_ev("mul1", c0 + 33, 32'h00010000, 1'b0, 1'b0, 32'h1);
    chk("mul1.extra_pulses", 64'(log_q.size()), 64'(0));

    // Illegal code followed by ADD
    c0 = cyc;
    issue(4'd5, 32'd1, 32'd2);
    issue(4'd2, 32'd1, 32'd1);
    idle(2);
    expect_ev("illegal",   c0 + 1, 32'd0, 1'b1, 1'b1, 32'd0);
    expect_ev("add_after", c0 + 2, 32'd2, 1'b0, 1'b0, 32'd0);

    // MUL of all-ones with an ADD accepted in the DONE cycle
    c0 = cyc;
    issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(32);
    issue(4'd2, 32'd4, 32'd5);
    idle(2);
    expect_ev("mul2",     c0 + 33, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFE);
    expect_ev("add_done", c0 + 34, 32'd9,        1'b0, 1'b0, 32'd0);

    // Reset in the middle of a MUL
    issue(4'd3, 32'd7, 32'd9);
    idle(9);
    rst_i = 1'b0;
    #2;
    chk("midrst.ready",  64'(ready_o),  64'(1));
    chk("midrst.valid",  64'(valid_o),  64'(0));
    chk("midrst.result", 64'(result_o), 64'(0));
    chk("midrst.zero",   64'(zero_o),   64'(0));
    chk("midrst.err",    64'(err_o),    64'(0));
    idle(2);
    rst_i = 1'b1;
    idle(40);
    chk("midrst.no_valid", 64'(log_q.size()), 64'(0));
    c0 = cyc;
    issue(4'd2, 32'd2, 32'd3);
    idle(2);
    expect_ev("add_after_rst", c0 + 1, 32'd5, 1'b0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
